// File: rtl/dpu_pkg.sv
// Shared mode encoding, pipeline latency and the signed-saturation helper
// for the dual-stage lane datapath.
package dpu_pkg;

   typedef enum logic [1:0] {
      PASS = 2'b00,
      ADD  = 2'b01,
      MAC  = 2'b10,
      MAX  = 2'b11
   } mode_e;

   localparam int LATENCY = 2;

   // Wide enough to hold a sign-extended 2*WIDTH product for WIDTH up to 64.
   localparam int SAT_W = 136;

   // Clamp a sign-extended value to the signed range of a w-bit word.
   function automatic logic [SAT_W-1:0] sat_clamp(input logic [SAT_W-1:0] v,
                                                  input int unsigned   w);
      logic [SAT_W-1:0] one;
      logic [SAT_W-1:0] hi;
      logic [SAT_W-1:0] lo;
      one = SAT_W'(1);
      hi  = (one << (w - 1)) - one;
      lo  = ~hi;
      if ($signed(v) > $signed(hi)) begin
         return hi;
      end else if ($signed(v) < $signed(lo)) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/dpu_lane.sv
// One datapath lane: S1 captures operands and the weighted product,
// S2 forms the mode-dependent result into the output registers.
module dpu_lane
   import dpu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SAT   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s1_en_i,
   input  logic             s2_en_i,
   input  mode_e            mode_i,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic [WIDTH-1:0] w_i,
   output logic [WIDTH-1:0] xout_o,
   output logic [WIDTH-1:0] yout_o
);

   logic [WIDTH-1:0]          x_q;
   logic [WIDTH-1:0]          y_q;
   logic [WIDTH-1:0]          p_q;
   logic [WIDTH-1:0]          p_d;
   logic [WIDTH-1:0]          xout_q;
   logic [WIDTH-1:0]          yout_q;
   logic [WIDTH-1:0]          yout_d;
   logic signed [2*WIDTH-1:0] prod;
   logic [WIDTH:0]            sum_add;
   logic [WIDTH:0]            sum_mac;

   // The product is clamped before it is stored, so the S2 add sees an
   // in-range addend when saturation is enabled.
   always_comb begin
      prod = $signed(x_i) * $signed(w_i);
      p_d  = prod[WIDTH-1:0];
      if (SAT != 0) begin
         p_d = WIDTH'(sat_clamp({{(SAT_W-2*WIDTH){prod[2*WIDTH-1]}}, prod}, WIDTH));
      end
   end

   always_comb begin
      sum_add = {y_q[WIDTH-1], y_q} + {x_q[WIDTH-1], x_q};
      sum_mac = {y_q[WIDTH-1], y_q} + {p_q[WIDTH-1], p_q};
      yout_d  = y_q;
      case (mode_i)
         PASS: yout_d = y_q;
         ADD: begin
            yout_d = sum_add[WIDTH-1:0];
            if (SAT != 0) begin
               yout_d = WIDTH'(sat_clamp({{(SAT_W-WIDTH-1){sum_add[WIDTH]}}, sum_add}, WIDTH));
            end
         end
         MAC: begin
            yout_d = sum_mac[WIDTH-1:0];
            if (SAT != 0) begin
               yout_d = WIDTH'(sat_clamp({{(SAT_W-WIDTH-1){sum_mac[WIDTH]}}, sum_mac}, WIDTH));
            end
         end
         MAX: yout_d = ($signed(y_q) > $signed(x_q)) ? y_q : x_q;
         default: yout_d = y_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q    <= '0;
         y_q    <= '0;
         p_q    <= '0;
         xout_q <= '0;
         yout_q <= '0;
      end else begin
         if (s1_en_i) begin
            x_q <= x_i;
            y_q <= y_i;
            p_q <= p_d;
         end
         if (s2_en_i) begin
            xout_q <= x_q;
            yout_q <= yout_d;
         end
      end
   end

   assign xout_o = xout_q;
   assign yout_o = yout_q;

endmodule

// File: rtl/dpu_pipe.sv
// Two-stage multi-lane datapath with valid/ready handshake, per-lane weight
// registers and a consumed-result counter.
module dpu_pipe
   import dpu_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int LANES = 2,
   parameter  int SAT   = 0,
   localparam int SELW  = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             mode,
   input  logic [LANES*WIDTH-1:0] xin,
   input  logic [LANES*WIDTH-1:0] yin,
   input  logic                   w_load,
   input  logic [SELW-1:0]        w_sel,
   input  logic [WIDTH-1:0]       w_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] xout,
   output logic [LANES*WIDTH-1:0] yout,
   output logic [15:0]            done_cnt
);

   logic [WIDTH-1:0] w_q [LANES];
   logic             s1_valid_q;
   logic             s1_valid_d;
   mode_e            s1_mode_q;
   mode_e            s1_mode_d;
   logic             out_valid_q;
   logic             out_valid_d;
   logic [15:0]      done_cnt_q;
   logic [15:0]      done_cnt_d;
   logic             stall;
   logic             accept;
   logic             s2_en;

   always_comb begin
      stall       = out_valid_q & ~out_ready;
      in_ready    = ~stall & ~rst;
      accept      = in_valid & in_ready;
      s2_en       = ~stall & s1_valid_q;
      s1_valid_d  = s1_valid_q;
      s1_mode_d   = s1_mode_q;
      out_valid_d = out_valid_q;
      done_cnt_d  = done_cnt_q;
      if (!stall) begin
         s1_valid_d  = accept;
         out_valid_d = s1_valid_q;
      end
      if (accept) begin
         s1_mode_d = mode_e'(mode);
      end
      if (out_valid_q && out_ready) begin
         done_cnt_d = done_cnt_q + 16'd1;
      end
   end

   // Weight writes land at the same edge that captures a concurrent
   // transaction, so that transaction still multiplies by the old weight.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_mode_q   <= PASS;
         out_valid_q <= 1'b0;
         done_cnt_q  <= '0;
         for (int i = 0; i < LANES; i++) begin
            w_q[i] <= '0;
         end
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_mode_q   <= s1_mode_d;
         out_valid_q <= out_valid_d;
         done_cnt_q  <= done_cnt_d;
         for (int i = 0; i < LANES; i++) begin
            if (w_load && (int'(w_sel) == i)) begin
               w_q[i] <= w_in;
            end
         end
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      dpu_lane #(
         .WIDTH (WIDTH),
         .SAT   (SAT)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .s1_en_i (accept),
         .s2_en_i (s2_en),
         .mode_i  (s1_mode_q),
         .x_i     (xin[i*WIDTH +: WIDTH]),
         .y_i     (yin[i*WIDTH +: WIDTH]),
         .w_i     (w_q[i]),
         .xout_o  (xout[i*WIDTH +: WIDTH]),
         .yout_o  (yout[i*WIDTH +: WIDTH])
      );
   end

   assign out_valid = out_valid_q;
   assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_dpu_pipe.sv
// Bench for dpu_pipe: a wrap-around and a saturating instance share stimulus,
// results are compared against a queue-based arithmetic reference model.
module tb_dpu_pipe;
   import dpu_pkg::*;

   localparam int W = 32;
   localparam int L = 2;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483647 - 64'sd1;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           out_ready;
   logic           w_load;
   logic [1:0]     mode;
   logic [L*W-1:0] xin;
   logic [L*W-1:0] yin;
   logic [0:0]     w_sel;
   logic [W-1:0]   w_in;

   logic           in_ready_a, out_valid_a, in_ready_b, out_valid_b;
   logic [L*W-1:0] xout_a, yout_a, xout_b, yout_b;
   logic [15:0]    done_a, done_b;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [L*W-1:0] x;
      logic [L*W-1:0] ya;
      logic [L*W-1:0] yb;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] ref_w [L];
   int           model_done = 0;

   always #5 clk = ~clk;

   dpu_pipe #(.WIDTH(W), .LANES(L), .SAT(0)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .mode(mode),
      .xin(xin), .yin(yin), .w_load(w_load), .w_sel(w_sel), .w_in(w_in),
      .out_valid(out_valid_a), .out_ready(out_ready), .xout(xout_a), .yout(yout_a),
      .done_cnt(done_a));

   dpu_pipe #(.WIDTH(W), .LANES(L), .SAT(1)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .mode(mode),
      .xin(xin), .yin(yin), .w_load(w_load), .w_sel(w_sel), .w_in(w_in),
      .out_valid(out_valid_b), .out_ready(out_ready), .xout(xout_b), .yout(yout_b),
      .done_cnt(done_b));

   function automatic longint clamp32(input longint v);
      if (v > SMAX) return SMAX;
      if (v < SMIN) return SMIN;
      return v;
   endfunction

   function automatic logic [W-1:0] ref_lane(input logic [1:0] m, input logic [W-1:0] x,
                                             input logic [W-1:0] y, input logic [W-1:0] w,
                                             input bit sat);
      longint xs, ys, ws, p, r;
      xs = longint'($signed(x));
      ys = longint'($signed(y));
      ws = longint'($signed(w));
      case (m)
         2'd0: r = ys;
         2'd1: begin
            r = ys + xs;
            if (sat) r = clamp32(r);
         end
         2'd2: begin
            p = xs * ws;
            if (sat) p = clamp32(p);
            r = ys + p;
            if (sat) r = clamp32(r);
         end
         default: r = (ys > xs) ? ys : xs;
      endcase
      return r[W-1:0];
   endfunction

   function automatic exp_t make_exp(input logic [1:0] m, input logic [L*W-1:0] x,
                                     input logic [L*W-1:0] y);
      exp_t e;
      e.x = x;
      for (int i = 0; i < L; i++) begin
         e.ya[i*W +: W] = ref_lane(m, x[i*W +: W], y[i*W +: W], ref_w[i], 1'b0);
         e.yb[i*W +: W] = ref_lane(m, x[i*W +: W], y[i*W +: W], ref_w[i], 1'b1);
      end
      return e;
   endfunction

   // Inputs change just after a rising edge, so at the falling edge they show
   // what the next rising edge will act on.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         for (int i = 0; i < L; i++) ref_w[i] = '0;
         model_done = 0;
      end else begin
         if (out_valid_a && out_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            model_done = (model_done + 1) % 65536;
         end
         if (in_valid && in_ready_a) exp_q.push_back(make_exp(mode, xin, yin));
         if (w_load) ref_w[w_sel] = w_in;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      w_load    = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic set_tx(input logic [1:0] m, input logic [W-1:0] x0, input logic [W-1:0] x1,
                         input logic [W-1:0] y0, input logic [W-1:0] y1);
      in_valid = 1'b1;
      mode     = m;
      xin      = {x1, x0};
      yin      = {y1, y0};
   endtask

   function automatic logic [W-1:0] rv();
      case ($urandom_range(0, 3))
         0: return W'($urandom_range(0, 15)) - 32'd8;
         1: return 32'h7FFF_FFFF - W'($urandom_range(0, 3));
         2: return 32'h8000_0000 + W'($urandom_range(0, 3));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1; idle(); in_valid = 1'b1; mode = 2'd1; xin = 64'h1; yin = 64'h2;
      #1;
      n_tests++;
      if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready_a); end
      cyc(); cyc();
      n_tests++;
      if (out_valid_a !== 1'b0 || done_a !== 16'd0) begin
         n_fail++; $display("FAIL rst_state: out_valid=%b done=%0d expected 0/0", out_valid_a, done_a);
      end
      n_tests++;
      if (xout_a !== '0 || yout_a !== '0) begin
         n_fail++; $display("FAIL rst_data: xout=%h yout=%h expected 0", xout_a, yout_a);
      end
      rst = 1'b0; in_valid = 1'b0;
      cyc(); cyc();
      n_tests++;
      if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_no_accept: out_valid=%b expected 0", out_valid_a); end
   endtask

   task automatic test_mac_basic();
      idle();
      w_load = 1'b1; w_sel = 1'b0; w_in = 32'd3; cyc();
      w_sel = 1'b1; w_in = 32'hFFFF_FFFE; cyc();
      w_load = 1'b0;
      set_tx(MAC, 32'd5, 32'd7, 32'd1, 32'd1);
      cyc();
      in_valid = 1'b0;
      n_tests++;
      if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL mac_lat1: out_valid=%b expected 0", out_valid_a); end
      cyc();
      n_tests++;
      if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL mac_lat2: out_valid=%b expected 1", out_valid_a); end
      n_tests++;
      if (yout_a !== {32'hFFFF_FFF3, 32'd16} || yout_b !== {32'hFFFF_FFF3, 32'd16}) begin
         n_fail++; $display("FAIL mac_yout: got %h / %h expected %h", yout_a, yout_b, {32'hFFFF_FFF3, 32'd16});
      end
      n_tests++;
      if (xout_a !== {32'd7, 32'd5}) begin n_fail++; $display("FAIL mac_xout: got %h expected %h", xout_a, {32'd7, 32'd5}); end
      cyc();
   endtask

   task automatic test_back_to_back();
      logic [1:0] modes [4];
      int seen, first, last, d0;
      modes[0] = PASS; modes[1] = ADD; modes[2] = MAC; modes[3] = MAX;
      seen = 0; first = -1; last = -1;
      rst = 1'b1; idle(); cyc(); rst = 1'b0;
      w_load = 1'b1; w_sel = 1'b0; w_in = 32'd2; cyc();
      w_sel = 1'b1; w_in = 32'hFFFF_FFFB; cyc();
      w_load = 1'b0;
      d0 = int'(done_a);
      for (int c = 0; c < 8; c++) begin
         if (c < 4) set_tx(modes[c], rv(), rv(), rv(), rv());
         else in_valid = 1'b0;
         cyc();
         if (out_valid_a) begin
            if (first < 0) first = c;
            last = c;
            seen++;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL b2b_extra: unexpected result yout=%h", yout_a);
            end else if (yout_a !== exp_q[0].ya || yout_b !== exp_q[0].yb || xout_a !== exp_q[0].x) begin
               n_fail++; $display("FAIL b2b_data: got %h/%h expected %h/%h", yout_a, yout_b, exp_q[0].ya, exp_q[0].yb);
            end
         end
      end
      n_tests++;
      if (seen != 4 || first != 1 || last != 4) begin
         n_fail++; $display("FAIL b2b_timing: seen=%0d first=%0d last=%0d expected 4/1/4", seen, first, last);
      end
      n_tests++;
      if (done_a !== 16'd4 || d0 != 0) begin n_fail++; $display("FAIL b2b_done: got %0d expected 4", done_a); end
   endtask

   task automatic test_stall();
      int acc;
      int tags[$];
      acc = 0;
      idle(); out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (acc < 3) set_tx(PASS, 32'd0, 32'd0, 32'd100 + W'(acc), 32'd0);
         else in_valid = 1'b0;
         #1;
         n_tests++;
         if (in_ready_a !== ((c < 2) ? 1'b1 : 1'b0)) begin
            n_fail++; $display("FAIL stall_in_ready c=%0d: got %b expected %b", c, in_ready_a, (c < 2));
         end
         if (in_valid && in_ready_a) acc++;
         cyc();
      end
      n_tests++;
      if (acc != 2 || out_valid_a !== 1'b1) begin
         n_fail++; $display("FAIL stall_hold: accepted=%0d out_valid=%b expected 2/1", acc, out_valid_a);
      end
      tags.push_back(int'(yout_a[W-1:0]));
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (acc < 3) set_tx(PASS, 32'd0, 32'd0, 32'd100 + W'(acc), 32'd0);
         else in_valid = 1'b0;
         #1;
         if (in_valid && in_ready_a) acc++;
         cyc();
         if (out_valid_a) tags.push_back(int'(yout_a[W-1:0]));
      end
      n_tests++;
      if (tags.size() != 3) begin
         n_fail++; $display("FAIL stall_count: got %0d results expected 3", tags.size());
      end else if (tags[0] != 100 || tags[1] != 101 || tags[2] != 102) begin
         n_fail++; $display("FAIL stall_order: got %0d,%0d,%0d expected 100,101,102", tags[0], tags[1], tags[2]);
      end
   endtask

   task automatic test_sat();
      idle();
      set_tx(ADD, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000);
      cyc(); in_valid = 1'b0; cyc();
      n_tests++;
      if (out_valid_a !== 1'b1 || yout_a !== {32'h0000_0000, 32'hFFFF_FFFE}) begin
         n_fail++; $display("FAIL add_wrap: got %h expected %h", yout_a, {32'h0000_0000, 32'hFFFF_FFFE});
      end
      n_tests++;
      if (yout_b !== {32'h8000_0000, 32'h7FFF_FFFF}) begin
         n_fail++; $display("FAIL add_sat: got %h expected %h", yout_b, {32'h8000_0000, 32'h7FFF_FFFF});
      end
      w_load = 1'b1; w_sel = 1'b0; w_in = 32'h4000_0000; cyc(); w_load = 1'b0;
      set_tx(MAC, 32'd4, 32'd0, 32'hFFFF_FFFF, 32'd0);
      cyc(); in_valid = 1'b0; cyc();
      n_tests++;
      if (yout_a[W-1:0] !== 32'hFFFF_FFFF || yout_b[W-1:0] !== 32'h7FFF_FFFE) begin
         n_fail++; $display("FAIL mac_sat: got %h/%h expected ffffffff/7ffffffe", yout_a[W-1:0], yout_b[W-1:0]);
      end
      cyc();
   endtask

   task automatic test_reset_inflight();
      idle();
      w_load = 1'b1; w_sel = 1'b0; w_in = 32'd5; cyc(); w_load = 1'b0;
      out_ready = 1'b0;
      set_tx(MAC, 32'd1, 32'd2, 32'd3, 32'd4); cyc();
      set_tx(MAC, 32'd5, 32'd6, 32'd7, 32'd8); cyc();
      rst = 1'b1; w_load = 1'b1; w_sel = 1'b0; w_in = 32'd77; in_valid = 1'b1;
      #1;
      n_tests++;
      if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL rst2_in_ready: got %b expected 0", in_ready_a); end
      cyc();
      rst = 1'b0; w_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      n_tests++;
      if (out_valid_a !== 1'b0 || done_a !== 16'd0) begin
         n_fail++; $display("FAIL rst2_state: out_valid=%b done=%0d expected 0/0", out_valid_a, done_a);
      end
      cyc(); cyc();
      n_tests++;
      if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst2_flush: out_valid=%b expected 0", out_valid_a); end
      set_tx(MAC, 32'd3, 32'd4, 32'd10, 32'd20);
      cyc(); in_valid = 1'b0; cyc();
      n_tests++;
      if (out_valid_a !== 1'b1 || yout_a !== {32'd20, 32'd10}) begin
         n_fail++; $display("FAIL rst2_weights: got %h expected %h", yout_a, {32'd20, 32'd10});
      end
      cyc();
   endtask

   task automatic test_weight_same_cycle();
      idle();
      w_load = 1'b1; w_sel = 1'b0; w_in = 32'd4; cyc();
      w_in = 32'd9;
      set_tx(MAC, 32'd1, 32'd0, 32'd0, 32'd0); cyc();
      w_load = 1'b0;
      set_tx(MAC, 32'd1, 32'd0, 32'd0, 32'd0); cyc();
      in_valid = 1'b0;
      n_tests++;
      if (out_valid_a !== 1'b1 || yout_a[W-1:0] !== 32'd4) begin
         n_fail++; $display("FAIL wsame_old: got %0d expected 4", yout_a[W-1:0]);
      end
      cyc();
      n_tests++;
      if (out_valid_a !== 1'b1 || yout_a[W-1:0] !== 32'd9) begin
         n_fail++; $display("FAIL wsame_new: got %0d expected 9", yout_a[W-1:0]);
      end
      cyc();
   endtask

   task automatic test_random();
      logic exp_rdy;
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 99) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         mode      = 2'($urandom_range(0, 3));
         xin       = {rv(), rv()};
         yin       = {rv(), rv()};
         out_ready = ($urandom_range(0, 9) < 7);
         w_load    = ($urandom_range(0, 9) < 2);
         w_sel     = 1'($urandom_range(0, 1));
         w_in      = rv();
         #1;
         exp_rdy = rst ? 1'b0 : !(out_valid_a && !out_ready);
         n_tests++;
         if (in_ready_a !== exp_rdy || in_ready_b !== exp_rdy) begin
            n_fail++; $display("FAIL rnd_in_ready i=%0d: got %b/%b expected %b", i, in_ready_a, in_ready_b, exp_rdy);
         end
         cyc();
         if (out_valid_a || out_valid_b) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rnd_extra i=%0d: unexpected result yout=%h", i, yout_a);
            end else if (yout_a !== exp_q[0].ya || yout_b !== exp_q[0].yb ||
                         xout_a !== exp_q[0].x || xout_b !== exp_q[0].x) begin
               n_fail++; $display("FAIL rnd_data i=%0d: got %h/%h expected %h/%h",
                                  i, yout_a, yout_b, exp_q[0].ya, exp_q[0].yb);
            end
         end
         n_tests++;
         if (int'(done_a) != model_done || int'(done_b) != model_done) begin
            n_fail++; $display("FAIL rnd_done i=%0d: got %0d/%0d expected %0d", i, done_a, done_b, model_done);
         end
      end
      rst = 1'b0; idle();
      repeat (4) cyc();
      n_tests++;
      if (exp_q.size() != 0 || out_valid_a !== 1'b0) begin
         n_fail++; $display("FAIL rnd_drain: %0d results never emerged, out_valid=%b", exp_q.size(), out_valid_a);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; w_load = 1'b0;
      mode = 2'd0; xin = '0; yin = '0; w_sel = 1'b0; w_in = '0;
      test_reset();
      test_mac_basic();
      test_back_to_back();
      test_stall();
      test_sat();
      test_reset_inflight();
      test_weight_same_cycle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/dpu_pipe.md
DPU_PIPE -- requirements
Module: dpu_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter LANES, default 2: number of parallel datapath lanes; legal range 1..8.
REQ-003 Parameter SAT, default 0: 1 selects signed saturation for the ADD and MAC modes; 0 selects wrap-around modulo 2^WIDTH.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  an input transaction is offered.
REQ-007 in_ready  output  1  the block accepts the offered transaction this cycle.
REQ-008 mode  input  2  operation for the offered transaction: 00 PASS, 01 ADD, 10 MAC, 11 MAX.
REQ-009 xin  input  LANES*WIDTH  packed x operands, lane 0 in the LSBs.
REQ-010 yin  input  LANES*WIDTH  packed y operands, lane 0 in the LSBs.
REQ-011 w_load  input  1  write w_in into the weight register of lane w_sel.
REQ-012 w_sel  input  $clog2(LANES) (minimum 1)  lane index for a weight write.
REQ-013 w_in  input  WIDTH  weight value to write.
REQ-014 out_valid  output  1  xout and yout hold a result.
REQ-015 out_ready  input  1  the downstream stage consumes the result.
REQ-016 xout  output  LANES*WIDTH  x operands forwarded, aligned with yout.
REQ-017 yout  output  LANES*WIDTH  results.
REQ-018 done_cnt  output  16  count of consumed results.

Function
REQ-019 A transaction SHALL be accepted when in_valid and in_ready are both high; it is consumed when out_valid and out_ready are both high.
REQ-020 The pipeline SHALL have two stages: S1 (multiply and operand capture) and S2 (add, saturate or max, then output registers). Latency is 2 cycles from acceptance to out_valid when the pipeline is not stalled.
REQ-021 The stall condition is stall = out_valid and not out_ready. in_ready SHALL equal not stall, so the full pipeline holds 2 transactions and no data is dropped or duplicated.
REQ-022 While stall is high, the S1 and S2 registers, xout and yout SHALL hold their values.
REQ-023 Per lane i, the result SHALL be:
- PASS: yout = yin
- ADD: yout = yin + xin
- MAC: yout = yin + w[i]*xin, using the low WIDTH bits of the signed product
- MAX: yout = the signed maximum of yin and xin
REQ-024 With SAT=1, ADD and MAC results SHALL clamp to the signed range [-2^(WIDTH-1), 2^(WIDTH-1)-1]. In MAC the product SHALL first be clamped to the same range before the add.
REQ-025 xout lane i SHALL equal the xin of the same transaction.
REQ-026 mode SHALL be captured at acceptance and carried with the transaction. Transactions with different modes SHALL coexist in the pipeline.
REQ-027 A weight write SHALL take effect on the next clock edge. A transaction accepted in the same cycle as a weight write SHALL use the old weight.
REQ-028 A weight write SHALL be honoured during stall.
REQ-029 done_cnt SHALL increment by 1 on each consumption and wrap from 65535 to 0.

Reset
REQ-030 When rst is high at a clock edge, the following SHALL be cleared: out_valid, the S1 valid, xout, yout, all weights and done_cnt. In-flight transactions are discarded.
REQ-031 During a cycle with rst high, in_ready SHALL be 0. Reset SHALL take priority over w_load and over acceptance in the same cycle.

Structure
REQ-032 Package dpu_pkg SHALL hold:
- the mode encoding constants PASS, ADD, MAC and MAX
- the LATENCY constant (2)
- the saturation helper function
REQ-033 One sub-module, dpu_lane, SHALL implement the single-lane datapath, instantiated LANES times.
REQ-034 The handshake, stall, weight decode and done_cnt logic SHALL live in dpu_pipe.

Verification (WIDTH=32, LANES=2)
REQ-035 Load w0=3 and w1=-2, then send MAC with x={5,7} and y={1,1}, out_ready=1 -> two cycles later out_valid=1, yout={16,-13}, xout={5,7}.
REQ-036 Send four back-to-back transactions (PASS, ADD, MAC, MAX) with out_ready=1 -> results appear in order on 4 consecutive cycles and done_cnt=4.
REQ-037 Send 3 transactions with out_ready held 0 -> in_ready drops after 2 are accepted; when out_ready is raised all 3 emerge in order, none lost.
REQ-038 SAT=1, ADD with x=y=0x7FFFFFFF -> yout=0x7FFFFFFF. SAT=0, same stimulus -> yout=0xFFFFFFFE.
REQ-039 Assert rst with 2 transactions in flight -> the next cycle out_valid=0, done_cnt=0 and weights=0; the next MAC returns yin.
REQ-040 Set w_load=1 with w0=9 in the same cycle as a MAC accepted with x0=1, y0=0 and old w0=4 -> yout0=4; the next MAC gives 9.
